// File: rtl/game_sequencer_pkg.sv
// Shared types and widths for the Watch-Your-Step game controller.
package game_sequencer_pkg;

  localparam int unsigned SCORE_W = 16;
  localparam int unsigned SPEED_W = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StPause = 2'd2,
    StOver  = 2'd3
  } state_e;

endpackage

// File: rtl/game_sequencer_if.sv
// Board/datapath-facing signal bundle of the game controller.
interface game_sequencer_if;
  import game_sequencer_pkg::*;

  logic               refresh;
  logic               btnC;
  logic               btnU;
  logic               btnL;
  logic [1:0]         sw;
  logic               collide;
  logic [1:0]         state;
  logic               run_en;
  logic               jump_go;
  logic               airborne;
  logic [SPEED_W-1:0] speed;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] hi_score;

  modport slave (
    input  refresh, btnC, btnU, btnL, sw, collide,
    output state, run_en, jump_go, airborne, speed, score, hi_score
  );

  modport master (
    output refresh, btnC, btnU, btnL, sw, collide,
    input  state, run_en, jump_go, airborne, speed, score, hi_score
  );

endinterface

// File: rtl/game_sequencer_btn.sv
// Raw button conditioner: 2-FF sync, debounce, one-cycle pulse on a debounced press.
module game_sequencer_btn #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic            deb_dly_q;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Debounced level flips only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    press_d = deb_q & ~deb_dly_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      press_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      press_q   <= press_d;
      cnt_q     <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/game_sequencer.sv
// Game controller: conditions buttons, runs IDLE/PLAY/PAUSE/OVER, schedules jumps, keeps score.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 1_000_000,
  parameter int unsigned JUMP_FRAMES    = 24,
  parameter int unsigned BASE_SPEED     = 1,
  parameter int unsigned MAX_SPEED      = 15,
  parameter int unsigned SPEEDUP_FRAMES = 600
) (
  input  logic              clkin,
  input  logic              rst,
  game_sequencer_if.slave   bus
);

  localparam int unsigned FrameW = $clog2(SPEEDUP_FRAMES + 1);
  localparam int unsigned JumpW  = $clog2(JUMP_FRAMES + 1);

  logic press_c, press_u, press_l;

  game_sequencer_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_c (
    .clk_i(clkin), .rst_i(rst), .btn_i(bus.btnC), .press_o(press_c)
  );
  game_sequencer_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_u (
    .clk_i(clkin), .rst_i(rst), .btn_i(bus.btnU), .press_o(press_u)
  );
  game_sequencer_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_l (
    .clk_i(clkin), .rst_i(rst), .btn_i(bus.btnL), .press_o(press_l)
  );

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] hi_q, hi_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [FrameW-1:0]  frame_q, frame_d;
  logic [JumpW-1:0]   jcnt_q, jcnt_d;
  logic               air_q, air_d;
  logic               jump_go_q, jump_go_d;
  logic [SPEED_W:0]   start_sum;
  logic [SPEED_W-1:0] start_speed;

  assign start_sum   = (SPEED_W + 1)'(BASE_SPEED) + (SPEED_W + 1)'(bus.sw);
  assign start_speed = (start_sum > (SPEED_W + 1)'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                               : start_sum[SPEED_W-1:0];

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    hi_d      = hi_q;
    speed_d   = speed_q;
    frame_d   = frame_q;
    jcnt_d    = jcnt_q;
    air_d     = air_q;
    jump_go_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press_c) begin
          state_d = StPlay;
          score_d = '0;
          speed_d = start_speed;
          frame_d = '0;
        end
      end
      StPlay: begin
        // A refresh is consumed under PLAY rules even if a button moves us out this cycle.
        if (bus.refresh && !bus.collide) begin
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
          if (frame_q == FrameW'(SPEEDUP_FRAMES - 1)) begin
            frame_d = '0;
            if (speed_q < SPEED_W'(MAX_SPEED)) speed_d = speed_q + SPEED_W'(1);
          end else begin
            frame_d = frame_q + FrameW'(1);
          end
        end
        if (jump_go_q) begin
          air_d  = 1'b1;
          jcnt_d = '0;
        end else if (air_q && bus.refresh) begin
          if (jcnt_q == JumpW'(JUMP_FRAMES - 1)) begin
            air_d  = 1'b0;
            jcnt_d = '0;
          end else begin
            jcnt_d = jcnt_q + JumpW'(1);
          end
        end
        if (press_l) begin
          state_d = StIdle;
        end else if (bus.refresh && bus.collide) begin
          state_d = StOver;
          hi_d    = (score_q > hi_q) ? score_q : hi_q;
        end else if (press_c) begin
          state_d = StPause;
        end
        if (state_d == StPlay) begin
          jump_go_d = press_u && !air_q && !jump_go_q;
        end else if (state_d != StPause) begin
          air_d  = 1'b0;
          jcnt_d = '0;
        end
      end
      StPause: begin
        if (press_l) begin
          state_d = StIdle;
          air_d   = 1'b0;
          jcnt_d  = '0;
        end else if (press_c) begin
          state_d = StPlay;
        end
      end
      StOver: begin
        if (press_c || press_l) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      score_q   <= '0;
      hi_q      <= '0;
      speed_q   <= SPEED_W'(BASE_SPEED);
      frame_q   <= '0;
      jcnt_q    <= '0;
      air_q     <= 1'b0;
      jump_go_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      hi_q      <= hi_d;
      speed_q   <= speed_d;
      frame_q   <= frame_d;
      jcnt_q    <= jcnt_d;
      air_q     <= air_d;
      jump_go_q <= jump_go_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.run_en   = (state_q == StPlay);
  assign bus.jump_go  = jump_go_q;
  assign bus.airborne = air_q;
  assign bus.speed    = speed_q;
  assign bus.score    = score_q;
  assign bus.hi_score = hi_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer (DEB_CYCLES=4, JUMP_FRAMES=3, SPEEDUP_FRAMES=5).
module tb_game_sequencer;

  logic clkin = 1'b0;
  logic rst   = 1'b1;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_jump = 0;

  game_sequencer_if bus ();

  game_sequencer #(
    .DEB_CYCLES    (4),
    .JUMP_FRAMES   (3),
    .BASE_SPEED    (1),
    .MAX_SPEED     (15),
    .SPEEDUP_FRAMES(5)
  ) dut (
    .clkin(clkin),
    .rst  (rst),
    .bus  (bus.slave)
  );

  always #5 clkin = ~clkin;

  always @(negedge clkin) if (bus.jump_go === 1'b1) n_jump++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic press(input logic c, input logic u, input logic l);
    bus.btnC = c;
    bus.btnU = u;
    bus.btnL = l;
    cyc(10);
    bus.btnC = 1'b0;
    bus.btnU = 1'b0;
    bus.btnL = 1'b0;
    cyc(10);
  endtask

  // Each frame: 70 quiet cycles then a one-cycle refresh (71-cycle period).
  task automatic frames(input int n, input logic col);
    for (int i = 0; i < n; i++) begin
      cyc(70);
      bus.refresh = 1'b1;
      bus.collide = col;
      cyc(1);
      bus.refresh = 1'b0;
      bus.collide = 1'b0;
    end
  endtask

  initial begin
    bus.refresh = 1'b0;
    bus.btnC    = 1'b0;
    bus.btnU    = 1'b0;
    bus.btnL    = 1'b0;
    bus.sw      = 2'd0;
    bus.collide = 1'b0;
    cyc(2);
    chk("rst_state", 16'(bus.state), 16'd0);
    chk("rst_speed", 16'(bus.speed), 16'd1);
    chk("rst_score", bus.score, 16'd0);
    chk("rst_run_en", 16'(bus.run_en), 16'd0);
    chk("rst_airborne", 16'(bus.airborne), 16'd0);
    rst = 1'b0;
    cyc(3);

    // Start with sw=2; press must take effect exactly 8 edges after the raw edge.
    bus.sw   = 2'd2;
    bus.btnC = 1'b1;
    cyc(7);
    chk("start_latency_early", 16'(bus.state), 16'd0);
    cyc(1);
    chk("start_state", 16'(bus.state), 16'd1);
    chk("start_speed", 16'(bus.speed), 16'd3);
    chk("start_run_en", 16'(bus.run_en), 16'd1);
    cyc(2);
    bus.btnC = 1'b0;
    cyc(10);

    frames(5, 1'b0);
    chk("score_5", bus.score, 16'd5);
    chk("speedup_4", 16'(bus.speed), 16'd4);

    // Jump: pulse 8 edges after btnU, airborne the cycle after.
    bus.btnU = 1'b1;
    cyc(8);
    chk("jump_go_pulse", 16'(bus.jump_go), 16'd1);
    chk("jump_air_not_yet", 16'(bus.airborne), 16'd0);
    cyc(1);
    chk("jump_go_drop", 16'(bus.jump_go), 16'd0);
    chk("jump_airborne", 16'(bus.airborne), 16'd1);
    bus.btnU = 1'b0;
    cyc(10);
    press(1'b0, 1'b1, 1'b0);
    chk("jump_while_air", 16'(n_jump), 16'd1);
    frames(2, 1'b0);
    chk("air_after_2", 16'(bus.airborne), 16'd1);
    frames(1, 1'b0);
    chk("air_after_3", 16'(bus.airborne), 16'd0);
    chk("score_8", bus.score, 16'd8);

    // 2-cycle glitch ignored; long hold gives a single pause entry.
    bus.btnC = 1'b1;
    cyc(2);
    bus.btnC = 1'b0;
    cyc(20);
    chk("glitch_ignored", 16'(bus.state), 16'd1);
    bus.btnC = 1'b1;
    cyc(1000);
    chk("held_pause", 16'(bus.state), 16'd2);
    bus.btnC = 1'b0;
    cyc(20);
    chk("held_once", 16'(bus.state), 16'd2);
    frames(2, 1'b0);
    chk("pause_score_frozen", bus.score, 16'd8);
    chk("pause_run_en", 16'(bus.run_en), 16'd0);

    press(1'b1, 1'b0, 1'b0);
    chk("resume", 16'(bus.state), 16'd1);
    frames(1, 1'b1);
    chk("collide_over", 16'(bus.state), 16'd3);
    chk("collide_score", bus.score, 16'd8);
    chk("collide_hi", bus.hi_score, 16'd8);

    press(1'b0, 1'b0, 1'b1);
    chk("over_to_idle", 16'(bus.state), 16'd0);
    chk("idle_score_hold", bus.score, 16'd8);
    press(1'b0, 1'b1, 1'b0);
    chk("jump_in_idle", 16'(n_jump), 16'd1);

    // Second game dies at 4; high score keeps 8.
    bus.sw = 2'd0;
    press(1'b1, 1'b0, 1'b0);
    chk("g2_state", 16'(bus.state), 16'd1);
    chk("g2_score_clr", bus.score, 16'd0);
    chk("g2_speed", 16'(bus.speed), 16'd1);
    frames(4, 1'b0);
    frames(1, 1'b1);
    chk("g2_over", 16'(bus.state), 16'd3);
    chk("g2_score", bus.score, 16'd4);
    chk("g2_hi_keep", bus.hi_score, 16'd8);
    press(1'b1, 1'b0, 1'b0);
    chk("g2_idle", 16'(bus.state), 16'd0);

    // btnL and btnC together in PLAY: abort wins.
    bus.sw = 2'd1;
    press(1'b1, 1'b0, 1'b0);
    chk("g3_speed", 16'(bus.speed), 16'd2);
    press(1'b1, 1'b0, 1'b1);
    chk("l_beats_c", 16'(bus.state), 16'd0);

    // collide and pressC land on the same refresh: collision wins.
    bus.sw = 2'd3;
    press(1'b1, 1'b0, 1'b0);
    chk("g4_speed", 16'(bus.speed), 16'd4);
    bus.btnC = 1'b1;
    cyc(7);
    bus.refresh = 1'b1;
    bus.collide = 1'b1;
    cyc(1);
    bus.refresh = 1'b0;
    bus.collide = 1'b0;
    chk("collide_beats_c", 16'(bus.state), 16'd3);
    chk("g4_hi_keep", bus.hi_score, 16'd8);
    bus.btnC = 1'b0;
    cyc(20);

    // Speed saturation: 4 + 11 increments over 55 frames, then held at 15.
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("g5_state", 16'(bus.state), 16'd1);
    frames(55, 1'b0);
    chk("speed_reach_15", 16'(bus.speed), 16'd15);
    frames(5, 1'b0);
    chk("speed_sat_15", 16'(bus.speed), 16'd15);
    chk("score_60", bus.score, 16'd60);

    force dut.score_q = 16'hFFFE;
    cyc(1);
    release dut.score_q;
    frames(1, 1'b0);
    chk("score_ffff", bus.score, 16'hFFFF);
    frames(1, 1'b0);
    chk("score_sat", bus.score, 16'hFFFF);

    // Asynchronous reset mid-PLAY.
    rst = 1'b1;
    #1;
    chk("arst_state", 16'(bus.state), 16'd0);
    chk("arst_score", bus.score, 16'd0);
    chk("arst_hi", bus.hi_score, 16'd0);
    chk("arst_speed", 16'(bus.speed), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
